// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, instruction field positions and a small
// decode helper shared by the operand issue stage and its scoreboard.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Which register fields an opcode actually uses.
    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic rd_writes;
    } dec_t;

    function automatic dec_t decode_op(input logic [6:0] opc);
        dec_t d;
        d.rs1_used  = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
        d.rs2_used  = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
        d.rd_writes = (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
                      (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_LUI) ||
                      (opc == OPC_AUIPC);
        return d;
    endfunction

endpackage

// File: rtl/operand_issue_stage_scoreboard.sv
// operand_issue_stage_scoreboard: one pending-write bit per architectural
// register. Bits are set on issue, cleared on writeback and cleared again when
// a flush discards an unaccepted packet that had set one. Three lookups feed
// the hazard output (rs1, rs2 and rd for WAW).
module operand_issue_stage_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    input  logic              fclr_en,
    input  logic [REG_AW-1:0] fclr_idx,
    input  logic              chk1_en,
    input  logic [REG_AW-1:0] chk1_idx,
    input  logic              chk2_en,
    input  logic [REG_AW-1:0] chk2_idx,
    input  logic              chk3_en,
    input  logic [REG_AW-1:0] chk3_idx,
    output logic              hazard
);

    localparam int NREGS = 1 << REG_AW;

    logic [NREGS-1:0] sb;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    // Build set/clear masks; writeback and flush clears may hit different bits.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) begin
            set_mask[set_idx] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_idx] = 1'b1;
        end
        if (fclr_en) begin
            clr_mask[fclr_idx] = 1'b1;
        end
    end

    // Pending-write register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~clr_mask) | set_mask;
        end
    end

    assign hazard = (chk1_en && sb[chk1_idx]) ||
                    (chk2_en && sb[chk2_idx]) ||
                    (chk3_en && sb[chk3_idx]);

endmodule

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: holds one fetched instruction, reads its operands from
// the register file, stalls on RAW/WAW hazards against the scoreboard and
// issues operand-complete packets over a valid/ready handshake.
// Optional feature macro: WB_BYPASS_EN (forward wb_data into a same-cycle
// source operand instead of waiting for the register file update).
module operand_issue_stage #(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int REG_AW = riscv_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic [REG_AW-1:0] A1,
    output logic [REG_AW-1:0] A2,
    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_rs1_val,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rd_we,
    output logic [CNT_W-1:0]  stall_cnt
);

    import riscv_pkg::*;

    logic              slot_valid;
    logic [XLEN-1:0]   slot_instr;
    logic [XLEN-1:0]   slot_pc;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    dec_t              dec;
    logic              rd_we;

    logic              byp1;
    logic              byp2;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              hazard;
    logic              issue;

    assign opcode = slot_instr[OPC_LSB +: 7];
    assign rs1    = slot_instr[RS1_LSB +: REG_AW];
    assign rs2    = slot_instr[RS2_LSB +: REG_AW];
    assign rd     = slot_instr[RD_LSB +: REG_AW];
    assign dec    = decode_op(opcode);
    assign rd_we  = dec.rd_writes && (rd != '0);

    assign A1 = slot_valid ? rs1 : '0;
    assign A2 = slot_valid ? rs2 : '0;

`ifdef WB_BYPASS_EN
    assign byp1 = wb_valid && (wb_rd == rs1) && (rs1 != '0);
    assign byp2 = wb_valid && (wb_rd == rs2) && (rs2 != '0);
    assign op1  = byp1 ? wb_data : RD1;
    assign op2  = byp2 ? wb_data : RD2;
`else
    logic wb_data_unused;
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign op1  = RD1;
    assign op2  = RD2;
    assign wb_data_unused = ^wb_data;
`endif

    operand_issue_stage_scoreboard #(
        .REG_AW (REG_AW)
    ) u_scoreboard (
        .clk      (clk),
        .Reset    (Reset),
        .set_en   (issue && rd_we),
        .set_idx  (rd),
        .clr_en   (wb_valid && (wb_rd != '0)),
        .clr_idx  (wb_rd),
        .fclr_en  (flush && out_valid && !out_ready && out_rd_we),
        .fclr_idx (out_rd),
        .chk1_en  (slot_valid && dec.rs1_used && (rs1 != '0) && !byp1),
        .chk1_idx (rs1),
        .chk2_en  (slot_valid && dec.rs2_used && (rs2 != '0) && !byp2),
        .chk2_idx (rs2),
        .chk3_en  (slot_valid && rd_we),
        .chk3_idx (rd),
        .hazard   (hazard)
    );

    assign issue    = slot_valid && !hazard && (!out_valid || out_ready) && !flush;
    assign in_ready = !flush && (!slot_valid || issue);

    // Decode slot: flush empties it, acceptance refills it, issue drains it.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            slot_valid <= 1'b0;
            slot_instr <= '0;
            slot_pc    <= '0;
        end else if (flush) begin
            slot_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            slot_valid <= 1'b1;
            slot_instr <= in_instr;
            slot_pc    <= in_pc;
        end else if (issue) begin
            slot_valid <= 1'b0;
        end
    end

    // Output packet register: held while execute is not ready.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_instr   <= '0;
            out_rs1_val <= '0;
            out_rs2_val <= '0;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid   <= 1'b1;
            out_pc      <= slot_pc;
            out_instr   <= slot_instr;
            out_rs1_val <= op1;
            out_rs2_val <= op2;
            out_rd      <= rd;
            out_rd_we   <= rd_we;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles a held instruction is blocked by a hazard.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= '0;
        end else if (slot_valid && hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_issue_stage.sv
// tb_operand_issue_stage: directed scenarios followed by a randomized run
// checked against an in-order transaction model with its own register file.
// Honours WB_BYPASS_EN the same way the design does.
module tb_operand_issue_stage;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = '0, in_pc = '0;
    logic [4:0]  A1, A2;
    logic [31:0] RD1, RD2;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [15:0] stall_cnt;

    logic [31:0] rf [32];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expQ[$];
    logic [4:0]  wbQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          lastAcc, lastFlush, holdPending;
    logic [31:0] holdPc, holdInstr, holdRs1, holdRs2, pcNext;

    always #5 clk = ~clk;

    // Register file seen by the stage: combinational read, x0 reads zero.
    always @(posedge clk) begin
        if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end
    assign RD1 = (A1 == 5'd0) ? 32'd0 : rf[A1];
    assign RD2 = (A2 == 5'd0) ? 32'd0 : rf[A2];

    operand_issue_stage dut (
        .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
    );

    // Architectural decode rules used by the model.
    function automatic bit usesRs1(input logic [6:0] o);
        return !(o == OP_LUI || o == OP_AUI || o == OP_JAL);
    endfunction
    function automatic bit usesRs2(input logic [6:0] o);
        return (o == OP_R || o == OP_ST || o == OP_BR);
    endfunction
    function automatic bit writesRd(input logic [31:0] ins);
        logic [6:0] o;
        o = ins[6:0];
        return (o == OP_R || o == OP_I || o == OP_LD || o == OP_JAL || o == OP_JR ||
                o == OP_LUI || o == OP_AUI) && (ins[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] o, input int rd, input int rs1, input int rs2);
        logic [4:0] a, b, c;
        a = rd[4:0];
        b = rs1[4:0];
        c = rs2[4:0];
        return {7'd0, c, b, 3'd0, a, o};
    endfunction

    function automatic logic [31:0] randInstr();
        logic [6:0]  opcs [9];
        logic [31:0] ins, r;
        opcs = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JR, OP_LUI, OP_AUI};
        ins = mk(opcs[$urandom_range(0, 8)], $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7));
        r = $urandom;
        ins[14:12] = r[2:0];
        ins[31:25] = r[9:3];
        return ins;
    endfunction

    function automatic logic [31:0] regVal(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : rf[r];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        wb_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        tick();
    endtask

    // One randomized (or draining) cycle: drive, settle, score, advance.
    task automatic applyStimulus(input bit drain);
        exp_t e;
        bit   accIn, accOut;
        if (drain) begin
            in_valid = 1'b0;
            flush = 1'b0;
            out_ready = 1'b1;
        end else begin
            if (!in_valid || lastAcc || lastFlush) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_instr = randInstr();
                    in_pc = pcNext;
                    pcNext = pcNext + 32'd4;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
        end
        if (wbQ.size() > 0 && $urandom_range(0, 2) == 0) begin
            wb_valid = 1'b1;
            wb_rd = wbQ.pop_front();
            wb_data = $urandom;
        end else begin
            wb_valid = 1'b0;
        end
        #1;
        if (holdPending) begin
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_pc", out_pc, holdPc);
            checkOutput("hold_instr", out_instr, holdInstr);
            checkOutput("hold_rs1", out_rs1_val, holdRs1);
            checkOutput("hold_rs2", out_rs2_val, holdRs2);
        end
        holdPending = out_valid && !out_ready && !flush;
        holdPc = out_pc;
        holdInstr = out_instr;
        holdRs1 = out_rs1_val;
        holdRs2 = out_rs2_val;
        accIn = in_valid && in_ready;
        accOut = out_valid && out_ready;
        if (accOut) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_packet", 32'(out_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pkt_pc", out_pc, e.pc);
                checkOutput("pkt_instr", out_instr, e.instr);
                checkOutput("pkt_rd", 32'(out_rd), 32'(e.instr[11:7]));
                checkOutput("pkt_rd_we", 32'(out_rd_we), 32'(writesRd(e.instr)));
                if (usesRs1(e.instr[6:0]))
                    checkOutput("pkt_rs1", out_rs1_val, regVal(e.instr[19:15]));
                if (usesRs2(e.instr[6:0]))
                    checkOutput("pkt_rs2", out_rs2_val, regVal(e.instr[24:20]));
                if (writesRd(e.instr)) wbQ.push_back(e.instr[11:7]);
            end
        end
        if (flush) expQ.delete();
        if (accIn) expQ.push_back('{pc: in_pc, instr: in_instr});
        lastAcc = accIn;
        lastFlush = flush;
        tick();
    endtask

    initial begin
        // Reset state
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("rst_A1", 32'(A1), 32'd0);
        checkOutput("rst_A2", 32'(A2), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_rs1", out_rs1_val, 32'd0);
        checkOutput("rst_out_rd_we", 32'(out_rd_we), 32'd0);
        doReset();

        // Preload the register file through the writeback port
        for (int i = 1; i < 32; i++) begin
            wb_valid = 1'b1;
            wb_rd = 5'(i);
            wb_data = (i == 2) ? 32'd5 : (i == 3) ? 32'd7 : 32'h1000 + 32'(i * 17);
            tick();
        end
        wb_valid = 1'b0;

        // Back-to-back independent instructions
        doReset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(OP_R, 1, 2, 3); in_pc = 32'h100;
        tick();
        in_instr = mk(OP_R, 4, 5, 6); in_pc = 32'h104;
        #1;
        checkOutput("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("b2b_valid0", 32'(out_valid), 32'd1);
        checkOutput("b2b_pc0", out_pc, 32'h100);
        checkOutput("b2b_rs1", out_rs1_val, 32'd5);
        checkOutput("b2b_rs2", out_rs2_val, 32'd7);
        checkOutput("b2b_rd0", 32'(out_rd), 32'd1);
        checkOutput("b2b_we0", 32'(out_rd_we), 32'd1);
        tick();
        checkOutput("b2b_valid1", 32'(out_valid), 32'd1);
        checkOutput("b2b_pc1", out_pc, 32'h104);
        checkOutput("b2b_rd1", 32'(out_rd), 32'd4);
        tick();
        checkOutput("b2b_drained", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_instr = mk(OP_R, 8, 1, 4); in_pc = 32'h108;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("b2b_sb_stall_valid", 32'(out_valid), 32'd0);
        checkOutput("b2b_sb_stall_cnt", 32'(stall_cnt), 32'd2);

        // RAW stall released by writeback
        doReset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(OP_I, 1, 0, 5); in_pc = 32'h200;
        tick();
        in_instr = mk(OP_R, 2, 1, 1); in_pc = 32'h204;
        tick();
        in_valid = 1'b0;
        checkOutput("raw_addi_rd", 32'(out_rd), 32'd1);
        tick();
        tick();
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'hABC;
        tick();
        wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
        checkOutput("raw_valid", 32'(out_valid), 32'd1);
        checkOutput("raw_stall_cnt", 32'(stall_cnt), 32'd2);
`else
        checkOutput("raw_not_yet", 32'(out_valid), 32'd0);
        tick();
        checkOutput("raw_valid", 32'(out_valid), 32'd1);
        checkOutput("raw_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
        checkOutput("raw_pc", out_pc, 32'h204);
        checkOutput("raw_rs1", out_rs1_val, 32'hABC);
        checkOutput("raw_rs2", out_rs2_val, 32'hABC);

        // Backpressure
        doReset();
        in_valid = 1'b1; in_instr = mk(OP_R, 10, 2, 3); in_pc = 32'h300;
        tick();
        in_instr = mk(OP_R, 11, 5, 6); in_pc = 32'h304;
        tick();
        in_instr = mk(OP_R, 12, 2, 2); in_pc = 32'h308;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_pc", out_pc, 32'h300);
            checkOutput("bp_rs1", out_rs1_val, 32'd5);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("bp_pc1", out_pc, 32'h304);
        checkOutput("bp_rd1", 32'(out_rd), 32'd11);
        tick();
        checkOutput("bp_pc2", out_pc, 32'h308);
        checkOutput("bp_rs2_2", out_rs2_val, 32'd5);
        tick();
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // Flush with an unaccepted packet writing x9
        doReset();
        in_valid = 1'b1; in_instr = mk(OP_I, 9, 0, 1); in_pc = 32'h400;
        tick();
        in_instr = mk(OP_R, 13, 2, 3); in_pc = 32'h404;
        tick();
        flush = 1'b1;
        in_instr = mk(OP_R, 14, 9, 0); in_pc = 32'h408;
        #1;
        checkOutput("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
        checkOutput("fl_slot_empty", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("fl_reissue_valid", 32'(out_valid), 32'd1);
        checkOutput("fl_reissue_pc", out_pc, 32'h408);
        checkOutput("fl_reissue_rs1", out_rs1_val, regVal(5'd9));
        checkOutput("fl_no_stall", 32'(stall_cnt), 32'd0);

        // x0 destination and sources
        doReset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(OP_I, 0, 0, 1); in_pc = 32'h500;
        tick();
        in_instr = mk(OP_R, 3, 0, 0); in_pc = 32'h504;
        tick();
        in_valid = 1'b0;
        checkOutput("x0_we", 32'(out_rd_we), 32'd0);
        checkOutput("x0_rd", 32'(out_rd), 32'd0);
        tick();
        checkOutput("x0_next_valid", 32'(out_valid), 32'd1);
        checkOutput("x0_next_pc", out_pc, 32'h504);
        checkOutput("x0_next_rs1", out_rs1_val, 32'd0);
        checkOutput("x0_next_we", 32'(out_rd_we), 32'd1);
        checkOutput("x0_no_stall", 32'(stall_cnt), 32'd0);

        // Asynchronous reset during a RAW stall
        doReset();
        in_valid = 1'b1; in_instr = mk(OP_I, 1, 0, 5); in_pc = 32'h600;
        tick();
        in_instr = mk(OP_R, 2, 1, 1); in_pc = 32'h604;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("ar_pre_stall", 32'(stall_cnt), 32'd2);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
        checkOutput("ar_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("ar_A1", 32'(A1), 32'd0);
        checkOutput("ar_out_pc", out_pc, 32'd0);
        @(negedge clk);
        Reset = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = mk(OP_R, 2, 1, 1); in_pc = 32'h608;
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("ar_sb_clear_valid", 32'(out_valid), 32'd1);
        checkOutput("ar_sb_clear_pc", out_pc, 32'h608);
        checkOutput("ar_sb_clear_stall", 32'(stall_cnt), 32'd0);

        // Randomized traffic against the in-order model
        doReset();
        expQ.delete();
        wbQ.delete();
        lastAcc = 1'b0;
        lastFlush = 1'b0;
        holdPending = 1'b0;
        pcNext = 32'h1000;
        for (int c = 0; c < 3000; c++) applyStimulus(1'b0);
        for (int c = 0; c < 400 && (expQ.size() > 0 || wbQ.size() > 0); c++) applyStimulus(1'b1);
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
